// File: rtl/alu_bus_seq.sv
// Multi-cycle RV32I ALU sequencer: reads rs1/rs2 over the shared bus, computes, writes rd back.
// Latency 4 (reg-reg) / 3 (imm) cycles plus n for shift-by-n; start is ignored while busy (ready=0).
module alu_bus_seq #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  output logic             done,
  input  logic [3:0]       op,
  input  logic [IDX_W-1:0] rs1,
  input  logic [IDX_W-1:0] rs2,
  input  logic [IDX_W-1:0] rd,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] imm,
  inout  wire  [WIDTH-1:0] bus,
  output logic [IDX_W-1:0] reg_idx,
  output logic             reg_en,
  output logic             reg_write
);

  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, SHIFT, WB} state_t;

  typedef struct packed {
    logic [3:0]       op;
    logic [IDX_W-1:0] rs1;
    logic [IDX_W-1:0] rs2;
    logic [IDX_W-1:0] rd;
    logic             use_imm;
    logic [WIDTH-1:0] imm;
  } cmd_t;

  state_t            state, next;
  cmd_t              cmd;
  logic [WIDTH-1:0]  a, b, r, alu, step;
  logic [SH_W-1:0]   cnt;
  logic              is_shift;

  assign is_shift = (cmd.op == 4'd1) || (cmd.op == 4'd5) || (cmd.op == 4'd13);

  // The bus is only ever driven by us in WB, when the register file is not enabled.
  assign bus = (state == WB) ? r : {WIDTH{1'bz}};

  always_comb begin
    alu = '0;
    case (cmd.op)
      4'd0:    alu = a + b;
      4'd8:    alu = a - b;
      4'd2:    alu = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'd3:    alu = {{(WIDTH-1){1'b0}}, (a < b)};
      4'd4:    alu = a ^ b;
      4'd6:    alu = a | b;
      4'd7:    alu = a & b;
      default: alu = '0;
    endcase
  end

  always_comb begin
    step = {1'b0, r[WIDTH-1:1]};
    case (cmd.op)
      4'd1:    step = {r[WIDTH-2:0], 1'b0};
      4'd13:   step = {r[WIDTH-1], r[WIDTH-1:1]};
      default: step = {1'b0, r[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next      = state;
    ready     = 1'b0;
    done      = 1'b0;
    reg_en    = 1'b0;
    reg_write = 1'b0;
    reg_idx   = '0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) next = RD_A;
      end
      RD_A: begin
        reg_idx = cmd.rs1;
        reg_en  = 1'b1;
        next    = cmd.use_imm ? EXEC : RD_B;
      end
      RD_B: begin
        reg_idx = cmd.rs2;
        reg_en  = 1'b1;
        next    = EXEC;
      end
      EXEC:  next = (is_shift && (b[SH_W-1:0] != '0)) ? SHIFT : WB;
      SHIFT: next = (cnt == SH_W'(1)) ? WB : SHIFT;
      WB: begin
        reg_idx   = cmd.rd;
        reg_write = 1'b1;
        done      = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd <= '0;
      a   <= '0;
      b   <= '0;
      r   <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE:  if (start) cmd <= {op, rs1, rs2, rd, use_imm, imm};
        RD_A: begin
          a <= bus;
          if (cmd.use_imm) b <= cmd.imm;
        end
        RD_B:  b <= bus;
        EXEC: begin
          r   <= is_shift ? a : alu;
          cnt <= b[SH_W-1:0];
        end
        SHIFT: begin
          r   <= step;
          cnt <= cnt - SH_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bus_seq.sv
// Bench for alu_bus_seq: behavioural register file on the bus plus a plain-arithmetic reference model.
module tb_alu_bus_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready, done;
  logic [3:0]  op;
  logic [4:0]  rs1, rs2, rd;
  logic        use_imm;
  logic [31:0] imm;
  wire  [31:0] bus;
  logic [4:0]  reg_idx;
  logic        reg_en, reg_write;

  logic [31:0] regs [32];
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign bus = reg_en ? regs[reg_idx] : 32'bz;

  alu_bus_seq #(.WIDTH(32), .IDX_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .done(done),
    .op(op), .rs1(rs1), .rs2(rs2), .rd(rd), .use_imm(use_imm), .imm(imm),
    .bus(bus), .reg_idx(reg_idx), .reg_en(reg_en), .reg_write(reg_write)
  );

  function automatic logic [31:0] ref_result(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int sh;
    logic signed [31:0] sx;
    sh = int'(y[4:0]);
    sx = x;
    case (o)
      4'd0:    return x + y;
      4'd8:    return x - y;
      4'd1:    return x << sh;
      4'd5:    return x >> sh;
      4'd13:   return sx >>> sh;
      4'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd3:    return (x < y) ? 32'd1 : 32'd0;
      4'd4:    return x ^ y;
      4'd6:    return x | y;
      4'd7:    return x & y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] o, input logic ui, input logic [31:0] y);
    int l;
    l = ui ? 3 : 4;
    if (o == 4'd1 || o == 4'd5 || o == 4'd13) l += int'(y[4:0]);
    return l;
  endfunction

  // Launch one op and watch it to completion; bus-protocol breaches are tallied in viol.
  task automatic run_op(input logic [3:0] o, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic ui, input logic [31:0] im, input int poke,
                        output int lat, output logic [31:0] wb_bus, output logic [4:0] wb_idx,
                        output logic wb_wr, output int viol, output logic rdy0);
    @(negedge clk);
    rdy0 = ready;
    op = o; rs1 = s1; rs2 = s2; rd = d; use_imm = ui; imm = im;
    start = 1'b1;
    lat = -1; viol = 0; wb_bus = '0; wb_idx = '0; wb_wr = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = (k == poke);
      if (reg_write && !done) viol++;
      if (reg_en && (done || reg_write)) viol++;
      if (reg_en && (bus !== regs[reg_idx])) viol++;
      if (done) begin
        lat = k; wb_bus = bus; wb_idx = reg_idx; wb_wr = reg_write;
        if (reg_write && reg_idx != 5'd0) regs[reg_idx] = bus;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0; use_imm = 1'b0; imm = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
    total++; if (reg_en !== 1'b0) $display("FAIL reset_reg_en got=%b exp=0", reg_en); else passed++;
    total++; if (reg_write !== 1'b0) $display("FAIL reset_reg_write got=%b exp=0", reg_write); else passed++;
    total++; if (reg_idx !== 5'd0) $display("FAIL reset_reg_idx got=%0d exp=0", reg_idx); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_add();
    int lat, viol; logic [31:0] wb; logic [4:0] idx; logic wr, r0;
    regs[1] = 32'd5; regs[2] = 32'd7;
    run_op(4'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0, 0, lat, wb, idx, wr, viol, r0);
    total++; if (lat !== 4) $display("FAIL add_latency got=%0d exp=4", lat); else passed++;
    total++; if (wb !== 32'd12) $display("FAIL add_bus got=%h exp=0000000c", wb); else passed++;
    total++; if (idx !== 5'd3) $display("FAIL add_idx got=%0d exp=3", idx); else passed++;
    total++; if (wr !== 1'b1) $display("FAIL add_write got=%b exp=1", wr); else passed++;
    total++; if (viol !== 0) $display("FAIL add_protocol got=%0d exp=0", viol); else passed++;
  endtask

  task automatic test_shift_imm();
    int lat, viol; logic [31:0] wb; logic [4:0] idx; logic wr, r0;
    regs[1] = 32'h8000_0000;
    run_op(4'd13, 5'd1, 5'd0, 5'd4, 1'b1, 32'd31, 0, lat, wb, idx, wr, viol, r0);
    total++; if (lat !== 34) $display("FAIL sra31_latency got=%0d exp=34", lat); else passed++;
    total++; if (wb !== 32'hFFFF_FFFF) $display("FAIL sra31_bus got=%h exp=ffffffff", wb); else passed++;
    total++; if (viol !== 0) $display("FAIL sra31_protocol got=%0d exp=0", viol); else passed++;
    run_op(4'd5, 5'd1, 5'd0, 5'd4, 1'b1, 32'd31, 0, lat, wb, idx, wr, viol, r0);
    total++; if (lat !== 34) $display("FAIL srl31_latency got=%0d exp=34", lat); else passed++;
    total++; if (wb !== 32'h0000_0001) $display("FAIL srl31_bus got=%h exp=00000001", wb); else passed++;
  endtask

  task automatic test_compare();
    int lat, viol; logic [31:0] wb; logic [4:0] idx; logic wr, r0;
    regs[1] = 32'hFFFF_FFFF; regs[2] = 32'd1;
    run_op(4'd2, 5'd1, 5'd2, 5'd6, 1'b0, 32'd0, 0, lat, wb, idx, wr, viol, r0);
    total++; if (wb !== 32'd1) $display("FAIL slt_bus got=%h exp=00000001", wb); else passed++;
    run_op(4'd3, 5'd1, 5'd2, 5'd6, 1'b0, 32'd0, 0, lat, wb, idx, wr, viol, r0);
    total++; if (wb !== 32'd0) $display("FAIL sltu_bus got=%h exp=00000000", wb); else passed++;
    run_op(4'd8, 5'd1, 5'd2, 5'd6, 1'b0, 32'd0, 0, lat, wb, idx, wr, viol, r0);
    total++; if (wb !== 32'hFFFF_FFFE) $display("FAIL sub_bus got=%h exp=fffffffe", wb); else passed++;
    run_op(4'd1, 5'd1, 5'd0, 5'd7, 1'b1, 32'd0, 0, lat, wb, idx, wr, viol, r0);
    total++; if (lat !== 3) $display("FAIL sll0_latency got=%0d exp=3", lat); else passed++;
    total++; if (wb !== 32'hFFFF_FFFF) $display("FAIL sll0_bus got=%h exp=ffffffff", wb); else passed++;
  endtask

  task automatic test_ignore_start_and_rd0();
    int lat, viol, extra; logic [31:0] wb; logic [4:0] idx; logic wr, r0, not_ready;
    regs[8] = 32'd100; regs[9] = 32'd23;
    run_op(4'd0, 5'd8, 5'd9, 5'd10, 1'b0, 32'd0, 2, lat, wb, idx, wr, viol, r0);
    total++; if (lat !== 4 || wb !== 32'd123) $display("FAIL poke_op got lat=%0d bus=%h exp lat=4 bus=0000007b", lat, wb); else passed++;
    extra = 0; not_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done) extra++;
      if (!ready) not_ready = 1'b1;
    end
    total++; if (extra !== 0) $display("FAIL poke_extra_done got=%0d exp=0", extra); else passed++;
    total++; if (not_ready !== 1'b0) $display("FAIL poke_stays_idle got busy=%b exp=0", not_ready); else passed++;
    run_op(4'd6, 5'd8, 5'd9, 5'd0, 1'b0, 32'd0, 0, lat, wb, idx, wr, viol, r0);
    total++; if (wr !== 1'b1 || idx !== 5'd0) $display("FAIL rd0_wb got wr=%b idx=%0d exp wr=1 idx=0", wr, idx); else passed++;
    total++; if (lat !== 4) $display("FAIL rd0_done got lat=%0d exp=4", lat); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    logic seen_wr, seen_done;
    regs[1] = 32'h1234_5678;
    @(negedge clk);
    op = 4'd5; rs1 = 5'd1; rs2 = 5'd0; rd = 5'd5; use_imm = 1'b1; imm = 32'd20; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    total++; if (ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", ready); else passed++;
    total++; if (reg_idx !== 5'd0 || reg_en !== 1'b0) $display("FAIL midrst_outputs got idx=%0d en=%b exp idx=0 en=0", reg_idx, reg_en); else passed++;
    seen_wr = 1'b0; seen_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (reg_write) seen_wr = 1'b1;
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    total++; if (seen_wr !== 1'b0) $display("FAIL midrst_no_write got=%b exp=0", seen_wr); else passed++;
    total++; if (seen_done !== 1'b0) $display("FAIL midrst_no_done got=%b exp=0", seen_done); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat, viol; logic [31:0] wb; logic [4:0] idx; logic wr, r0;
    regs[11] = 32'd40; regs[12] = 32'd2;
    run_op(4'd0, 5'd11, 5'd12, 5'd11, 1'b0, 32'd0, 0, lat, wb, idx, wr, viol, r0);
    run_op(4'd8, 5'd11, 5'd12, 5'd11, 1'b0, 32'd0, 0, lat, wb, idx, wr, viol, r0);
    total++; if (r0 !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", r0); else passed++;
    total++; if (lat !== 4 || wb !== 32'd40) $display("FAIL b2b_second got lat=%0d bus=%h exp lat=4 bus=00000028", lat, wb); else passed++;
  endtask

  task automatic test_random();
    int lat, viol, elat; logic [31:0] wb, ea, eb, eres; logic [4:0] idx, s1, s2, d; logic wr, r0, ui;
    logic [3:0] o; logic [31:0] im;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int n = 0; n < 40; n++) begin
      o  = 4'($urandom_range(0, 15));
      s1 = 5'($urandom_range(0, 31));
      s2 = 5'($urandom_range(0, 31));
      d  = 5'($urandom_range(0, 31));
      ui = 1'($urandom_range(0, 1));
      im = $urandom;
      if ($urandom_range(0, 1) == 0) im = 32'($urandom_range(0, 7));
      ea = regs[s1];
      eb = ui ? im : regs[s2];
      eres = ref_result(o, ea, eb);
      elat = ref_latency(o, ui, eb);
      run_op(o, s1, s2, d, ui, im, 0, lat, wb, idx, wr, viol, r0);
      total++; if (lat !== elat) $display("FAIL rand%0d_latency op=%0d got=%0d exp=%0d", n, o, lat, elat); else passed++;
      total++; if (wb !== eres) $display("FAIL rand%0d_bus op=%0d got=%h exp=%h", n, o, wb, eres); else passed++;
      total++; if (idx !== d || wr !== 1'b1) $display("FAIL rand%0d_wb got idx=%0d wr=%b exp idx=%0d wr=1", n, idx, wr, d); else passed++;
      total++; if (viol !== 0) $display("FAIL rand%0d_protocol got=%0d exp=0", n, viol); else passed++;
      total++; if (r0 !== 1'b1) $display("FAIL rand%0d_ready got=%b exp=1", n, r0); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    test_reset();
    test_add();
    test_shift_imm();
    test_compare();
    test_ignore_start_and_rd0();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
